// File: rtl/an13_decode_sched.sv
// Two-requester round-robin scheduler feeding a 2-stage A=13 Barrett AN-decode pipeline.
// Optional macro AN13_ERR_DROP_EN: suppress erroneous results and count them at the stage-2 load.
module an13_decode_sched #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [5:0]       in0_cw,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [5:0]       in1_cw,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_q,
    output logic [3:0]       out_r,
    output logic             out_err,
    output logic             out_src,
    output logic [5:0]       out_cw,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             err_clr
);

    logic       en;
    logic       grant;
    logic       accept;
    logic       last_grant_reg;
    logic [5:0] sel_cw;
    logic [9:0] q_wide;
    logic [2:0] q_t;
    logic [4:0] r_t;

    logic       s1_valid_reg;
    logic       s1_src_reg;
    logic [5:0] s1_cw_reg;
    logic [2:0] s1_q_reg;
    logic [4:0] s1_r_reg;

    logic       fix;
    logic [2:0] q_next;
    logic [3:0] r_next;
    logic       err_next;
    logic       cnt_inc;

    always_comb begin
        en = !out_valid || out_ready;
        // With both requesting, the one not served last time wins.
        if (in0_valid && in1_valid) begin
            grant = !last_grant_reg;
        end else begin
            grant = in1_valid;
        end
        accept    = en && (in0_valid || in1_valid);
        in0_ready = accept && !grant;
        in1_ready = accept && grant;
        sel_cw    = grant ? in1_cw : in0_cw;
        // 9/128 approximates 1/13; the estimate may undershoot by one.
        q_wide    = 10'(sel_cw) * 10'd9;
        q_t       = q_wide[9:7];
        r_t       = 5'(sel_cw - 6'(q_t) * 6'd13);
    end

    always_comb begin
        fix      = (s1_r_reg >= 5'd13);
        q_next   = fix ? s1_q_reg + 3'd1 : s1_q_reg;
        r_next   = fix ? 4'(s1_r_reg - 5'd13) : s1_r_reg[3:0];
        err_next = (r_next != 4'd0);
`ifdef AN13_ERR_DROP_EN
        cnt_inc  = en && s1_valid_reg && err_next;
`else
        cnt_inc  = out_valid && out_ready && out_err;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_reg <= 1'b1;
            s1_valid_reg   <= 1'b0;
            s1_src_reg     <= 1'b0;
            s1_cw_reg      <= '0;
            s1_q_reg       <= '0;
            s1_r_reg       <= '0;
            out_valid      <= 1'b0;
            out_q          <= '0;
            out_r          <= '0;
            out_err        <= 1'b0;
            out_src        <= 1'b0;
            out_cw         <= '0;
        end else if (en) begin
            if (accept) begin
                last_grant_reg <= grant;
            end
            s1_valid_reg <= accept;
            s1_src_reg   <= grant;
            s1_cw_reg    <= sel_cw;
            s1_q_reg     <= q_t;
            s1_r_reg     <= r_t;
`ifdef AN13_ERR_DROP_EN
            out_valid    <= s1_valid_reg && !err_next;
`else
            out_valid    <= s1_valid_reg;
`endif
            out_q        <= q_next;
            out_r        <= r_next;
            out_err      <= err_next;
            out_src      <= s1_src_reg;
            out_cw       <= s1_cw_reg;
        end
    end

    // Clear beats a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            err_cnt <= '0;
        end else if (cnt_inc && !(&err_cnt)) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_an13_decode_sched.sv
// Randomized scoreboard bench for an13_decode_sched: reference model uses integer divide/modulo.
module tb_an13_decode_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       in0_valid, in1_valid;
    logic       in0_ready, in1_ready;
    logic [5:0] in0_cw, in1_cw;
    logic       out_valid, out_ready;
    logic [2:0] out_q;
    logic [3:0] out_r;
    logic       out_err, out_src;
    logic [5:0] out_cw;
    logic [7:0] err_cnt;
    logic       err_clr;

    typedef struct packed {
        logic [2:0] q;
        logic [3:0] r;
        logic       err;
        logic       src;
        logic [5:0] cw;
    } res_t;

    res_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    bit   m_last = 1'b1;
    int   m_cnt = 0;

    an13_decode_sched #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_cw(in0_cw),
        .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_cw(in1_cw),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_q(out_q), .out_r(out_r), .out_err(out_err), .out_src(out_src), .out_cw(out_cw),
        .err_cnt(err_cnt), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic res_t ref_model(input logic [5:0] cw, input logic src);
        res_t e;
        int   v;
        v     = int'(cw);
        e.q   = 3'(v / 13);
        e.r   = 4'(v % 13);
        e.err = (v % 13) != 0;
        e.src = src;
        e.cw  = cw;
        return e;
    endfunction

    // Request side: check arbitration against the round-robin rule, log accepted codewords.
    always @(negedge clk) begin
        bit en_m, exp_r0, exp_r1;
        en_m   = !out_valid || out_ready;
        exp_r0 = en_m && in0_valid && (!in1_valid || m_last);
        exp_r1 = en_m && in1_valid && (!in0_valid || !m_last);
        chk("in0_ready", int'(in0_ready), int'(exp_r0));
        chk("in1_ready", int'(in1_ready), int'(exp_r1));
        if (rst) begin
            m_last = 1'b1;
        end else if (in0_valid && in0_ready) begin
            sb.push_back(ref_model(in0_cw, 1'b0));
            m_last = 1'b0;
        end else if (in1_valid && in1_ready) begin
            sb.push_back(ref_model(in1_cw, 1'b1));
            m_last = 1'b1;
        end
    end

    // Result side: presented result must match the oldest outstanding entry while it waits.
    always @(negedge clk) begin
        res_t e;
        bit   fire_err;
        fire_err = 1'b0;
        chk("err_cnt", int'(err_cnt), m_cnt);
        if (rst) begin
            sb.delete();
            m_cnt = 0;
        end else begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_result: got cw=%0d with no entry outstanding", out_cw);
                end else begin
                    e = sb[0];
                    chk("result", int'({out_q, out_r, out_err, out_src, out_cw}), int'(e));
                    if (out_ready) begin
                        void'(sb.pop_front());
                        fire_err = e.err;
                        $display("result src=%0d cw=%0d q=%0d r=%0d err=%0d", e.src, e.cw, e.q, e.r, e.err);
                    end
                end
            end
            if (err_clr) m_cnt = 0;
            else if (fire_err && m_cnt < 255) m_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        out_ready = 1'b1;
        err_clr   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        idle_inputs();
        for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
        tick();
        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d entries outstanding, required 0", sb.size());
        end
    endtask

    initial begin
        in0_cw = '0;
        in1_cw = '0;
        do_reset();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_fields", int'({out_q, out_r, out_err, out_src, out_cw}), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);

        // Single codeword needing correction; observe the two-cycle latency.
        in0_valid = 1'b1;
        in0_cw    = 6'd26;
        tick();
        in0_valid = 1'b0;
        chk("lat_t1_valid", int'(out_valid), 0);
        tick();
        chk("lat_t2_valid", int'(out_valid), 1);
        chk("lat_t2_q", int'(out_q), 2);
        chk("lat_t2_r", int'(out_r), 0);
        chk("lat_t2_src", int'(out_src), 0);
        drain();

        // Both requesters held: grants alternate starting with requester 0.
        do_reset();
        in0_valid = 1'b1;
        in0_cw    = 6'd63;
        in1_valid = 1'b1;
        in1_cw    = 6'd39;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("alt_grant0", int'(in0_ready), (i % 2 == 0) ? 1 : 0);
            tick();
        end
        drain();

        // Fill the pipeline, then stall the consumer for three cycles.
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in0_cw = 6'($urandom_range(0, 63));
            in1_cw = 6'($urandom_range(0, 63));
            tick();
        end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in0_cw = 6'($urandom_range(0, 63));
            in1_cw = 6'($urandom_range(0, 63));
            #1;
            chk("stall_ready", int'({in0_ready, in1_ready}), 0);
            tick();
        end
        drain();

        // Full codeword sweep from requester 1.
        err_clr = 1'b1;
        tick();
        err_clr   = 1'b0;
        in1_valid = 1'b1;
        for (int cw = 0; cw < 64; cw++) begin
            in1_cw = 6'(cw);
            tick();
        end
        drain();
        chk("sweep_err_cnt", int'(err_cnt), 59);

        // Saturation, then a clear that coincides with a delivered error.
        in0_valid = 1'b1;
        in0_cw    = 6'd1;
        for (int i = 0; i < 262; i++) tick();
        chk("sat_err_cnt", int'(err_cnt), 255);
        chk("sat_fire_err", int'(out_valid && out_err), 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_err_cnt", int'(err_cnt), 0);
        drain();

        // Random traffic with random backpressure and clears.
        for (int i = 0; i < 400; i++) begin
            in0_valid = 1'($urandom_range(0, 1));
            in1_valid = 1'($urandom_range(0, 1));
            in0_cw    = 6'($urandom_range(0, 63));
            in1_cw    = 6'($urandom_range(0, 63));
            out_ready = ($urandom_range(0, 3) != 0);
            err_clr   = ($urandom_range(0, 31) == 0);
            tick();
        end
        drain();

        // Reset with two entries in flight.
        in0_valid = 1'b1;
        in0_cw    = 6'd1;
        tick();
        tick();
        in0_valid = 1'b0;
        rst       = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_valid", int'(out_valid), 0);
        chk("rst_mid_err_cnt", int'(err_cnt), 0);
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        in0_cw    = 6'd13;
        in1_cw    = 6'd52;
        #1;
        chk("rst_mid_grant", int'({in0_ready, in1_ready}), 2);
        tick();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
